// File: rtl/fan_speed_ctrl.sv
// rtl/fan_speed_ctrl.sv - fan duty-cycle controller with hysteresis, kick-start and slew-limited ramp
module fan_speed_ctrl #(
  parameter int TICK_DIV   = 1024,
  parameter int KICK_TICKS = 4,
  parameter int T_ON       = 25,
  parameter int HYST       = 2,
  parameter int SLOPE      = 12,
  parameter int MIN_SPEED  = 64,
  parameter int STEP       = 8
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       enable,
  input  logic [7:0] temp,
  input  logic       temp_valid,
  output logic [7:0] speed,
  output logic       fan_on,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_KICK = 2'd1,
    S_RAMP = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]  KICK_LAST = 8'(KICK_TICKS - 1);
  localparam logic [7:0]  T_ON_8    = 8'(T_ON);
  localparam logic [7:0]  T_OFF_8   = 8'(T_ON - HYST);
  localparam logic [7:0]  STEP_8    = 8'(STEP);

  state_t      st;
  logic [7:0]  temp_lat;
  logic [15:0] tick_cnt;
  logic [7:0]  kick_cnt;
  logic        tick;
  logic [7:0]  target;
  logic [7:0]  ramp_next;
  logic [31:0] target_raw;
  logic [7:0]  gap;

  assign state = st;
  assign tick  = (tick_cnt == TICK_LAST);

  // Wide intermediate so a hot sample saturates at full duty instead of wrapping.
  always_comb begin
    target_raw = 32'(MIN_SPEED);
    if (temp_lat > T_ON_8)
      target_raw = 32'(MIN_SPEED) + 32'(temp_lat - T_ON_8) * 32'(SLOPE);
    target = (target_raw > 32'd255) ? 8'hff : target_raw[7:0];
  end

  // One slew-limited step toward target; the last step lands exactly on it.
  always_comb begin
    ramp_next = speed;
    gap       = 8'd0;
    if (speed > target) begin
      gap       = speed - target;
      ramp_next = speed - ((gap < STEP_8) ? gap : STEP_8);
    end else if (speed < target) begin
      gap       = target - speed;
      ramp_next = speed + ((gap < STEP_8) ? gap : STEP_8);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      st       <= S_OFF;
      speed    <= 8'd0;
      fan_on   <= 1'b0;
      temp_lat <= 8'd0;
      tick_cnt <= 16'd0;
      kick_cnt <= 8'd0;
    end else begin
      if (temp_valid)
        temp_lat <= temp;
      tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;

      if (st != S_OFF && (!enable || temp_lat < T_OFF_8)) begin
        st     <= S_OFF;
        speed  <= 8'd0;
        fan_on <= 1'b0;
      end else begin
        case (st)
          S_OFF: begin
            if (enable && temp_lat >= T_ON_8) begin
              st       <= S_KICK;
              speed    <= 8'hff;
              fan_on   <= 1'b1;
              kick_cnt <= 8'd0;
              tick_cnt <= 16'd0;
            end
          end
          S_KICK: begin
            if (tick) begin
              kick_cnt <= kick_cnt + 8'd1;
              if (kick_cnt == KICK_LAST)
                st <= S_RAMP;
            end
          end
          S_RAMP: begin
            if (tick) begin
              speed <= ramp_next;
              if (ramp_next == target)
                st <= S_RUN;
            end else if (speed == target) begin
              st <= S_RUN;
            end
          end
          S_RUN: begin
            if (speed != target)
              st <= S_RAMP;
          end
          default: st <= S_OFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// tb/tb_fan_speed_ctrl.sv - self-checking bench for fan_speed_ctrl
module tb_fan_speed_ctrl;

  localparam int TD    = 4;
  localparam int KT    = 4;
  localparam int T_ON  = 25;
  localparam int HYST  = 2;
  localparam int SLOPE = 12;
  localparam int MINSP = 64;
  localparam int STEP  = 8;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] temp = 8'd0;
  logic       temp_valid = 1'b0;
  logic [7:0] speed;
  logic       fan_on;
  logic [1:0] state;

  fan_speed_ctrl #(
    .TICK_DIV(TD), .KICK_TICKS(KT), .T_ON(T_ON), .HYST(HYST),
    .SLOPE(SLOPE), .MIN_SPEED(MINSP), .STEP(STEP)
  ) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .temp(temp),
    .temp_valid(temp_valid), .speed(speed), .fan_on(fan_on), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain integers, kick measured in cycles, tick phase from a modulo.
  int m_state, m_speed, m_lat, m_phase, m_kick_left;

  function automatic int target_of(input int t);
    int v;
    v = (t <= T_ON) ? MINSP : MINSP + (t - T_ON) * SLOPE;
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_speed = 0; m_lat = 0; m_phase = 0; m_kick_left = 0;
  endtask

  task automatic model_edge(input int en, input int t, input int tv);
    bit is_tick;
    int tgt, d;
    is_tick = (m_phase % TD) == (TD - 1);
    tgt = target_of(m_lat);
    m_phase++;
    if (m_state != 0 && (en == 0 || m_lat < T_ON - HYST)) begin
      m_state = 0; m_speed = 0;
    end else begin
      case (m_state)
        0: if (en != 0 && m_lat >= T_ON) begin
             m_state = 1; m_speed = 255; m_kick_left = KT * TD; m_phase = 0;
           end
        1: begin
             m_kick_left--;
             if (m_kick_left == 0) m_state = 2;
           end
        2: if (is_tick) begin
             d = tgt - m_speed;
             if (d > STEP) d = STEP;
             if (d < -STEP) d = -STEP;
             m_speed += d;
             if (m_speed == tgt) m_state = 3;
           end else if (m_speed == tgt) m_state = 3;
        default: if (m_speed != tgt) m_state = 2;
      endcase
    end
    if (tv != 0) m_lat = t;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(int'(enable), int'(temp), int'(temp_valid));
    #1;
    check("model_state", int'(state), m_state);
    check("model_speed", int'(speed), m_speed);
    check("model_fan_on", int'(fan_on), int'(m_state != 0));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  typedef struct {
    logic       en;
    logic [7:0] t;
    logic       tv;
    int         n;
    int         st;
    int         sp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int s0, cnt;
    bit done;

    vecs.push_back('{1'b1, 8'd20, 1'b1, 100, 0, 0});
    vecs.push_back('{1'b1, 8'd30, 1'b1, 1,   0, 0});
    vecs.push_back('{1'b1, 8'd30, 1'b0, 1,   1, 255});
    vecs.push_back('{1'b1, 8'd30, 1'b0, 15,  1, 255});
    vecs.push_back('{1'b1, 8'd30, 1'b0, 1,   2, 255});
    vecs.push_back('{1'b1, 8'd30, 1'b0, 3,   2, 255});
    vecs.push_back('{1'b1, 8'd30, 1'b0, 1,   2, 247});
    vecs.push_back('{1'b1, 8'd30, 1'b0, 4,   2, 239});
    vecs.push_back('{1'b1, 8'd30, 1'b0, 56,  2, 127});
    vecs.push_back('{1'b1, 8'd30, 1'b0, 4,   3, 124});
    vecs.push_back('{1'b1, 8'd23, 1'b1, 1,   3, 124});
    vecs.push_back('{1'b1, 8'd23, 1'b0, 1,   2, 124});
    vecs.push_back('{1'b1, 8'd23, 1'b0, 40,  3, 64});
    vecs.push_back('{1'b1, 8'd22, 1'b1, 1,   3, 64});
    vecs.push_back('{1'b1, 8'd22, 1'b0, 1,   0, 0});
    vecs.push_back('{1'b1, 8'd24, 1'b1, 1,   0, 0});
    vecs.push_back('{1'b1, 8'd24, 1'b0, 10,  0, 0});
    vecs.push_back('{1'b1, 8'd25, 1'b1, 1,   0, 0});
    vecs.push_back('{1'b1, 8'd25, 1'b0, 1,   1, 255});
    vecs.push_back('{1'b1, 8'd25, 1'b0, 120, 3, 64});
    vecs.push_back('{1'b1, 8'd60, 1'b1, 1,   3, 64});
    vecs.push_back('{1'b1, 8'd60, 1'b0, 1,   2, 64});
    vecs.push_back('{1'b1, 8'd60, 1'b0, 100, 3, 255});
    vecs.push_back('{1'b1, 8'd23, 1'b1, 1,   3, 255});
    vecs.push_back('{1'b1, 8'd23, 1'b0, 110, 3, 64});

    model_reset();
    enable = 1'b1; temp = 8'd20; temp_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", int'(state), 0);
    check("reset_speed", int'(speed), 0);
    check("reset_fan_on", int'(fan_on), 0);
    arst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      enable = vecs[i].en; temp = vecs[i].t; temp_valid = vecs[i].tv;
      run(vecs[i].n);
      check($sformatf("vec%0d_state", i), int'(state), vecs[i].st);
      check($sformatf("vec%0d_speed", i), int'(speed), vecs[i].sp);
    end

    // Direction reversal mid-ramp
    temp = 8'd60; temp_valid = 1'b1; cycle();
    temp_valid = 1'b0; run(21);
    temp = 8'd26; temp_valid = 1'b1; cycle();
    temp_valid = 1'b0;
    s0 = m_speed;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      cycle();
      if (m_speed != s0) done = 1;
    end
    check("reversal_seen", int'(done), 1);
    check("reversal_step", int'(speed), s0 - STEP);
    check("reversal_state", int'(state), 2);

    // Enable override during KICK, then a fresh full kick
    enable = 1'b0; cycle();
    check("disable_state", int'(state), 0);
    enable = 1'b1; cycle();
    check("kick1_state", int'(state), 1);
    run(5);
    enable = 1'b0; cycle();
    check("kick_abort_state", int'(state), 0);
    check("kick_abort_speed", int'(speed), 0);
    enable = 1'b1; cycle();
    check("rekick_state", int'(state), 1);
    check("rekick_speed", int'(speed), 255);
    cnt = 0;
    while (state == 2'd1 && cnt < 40) begin
      cycle();
      cnt++;
    end
    check("kick_length", cnt, KT * TD);
    run(6);
    check("midramp_state", int'(state), 2);

    // Asynchronous reset mid-RAMP, observed before the next clock edge
    arst_n = 1'b0;
    #1;
    model_reset();
    check("arst_state", int'(state), 0);
    check("arst_speed", int'(speed), 0);
    check("arst_fan_on", int'(fan_on), 0);
    @(posedge clk); #1;
    check("arst_hold_state", int'(state), 0);
    arst_n = 1'b1;
    temp_valid = 1'b0;
    run(20);
    check("no_kick_resume", int'(state), 0);

    // Randomized stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      enable = ($urandom_range(0, 29) != 0);
      temp_valid = ($urandom_range(0, 11) == 0);
      temp = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255))
                                         : 8'($urandom_range(18, 40));
      if ($urandom_range(0, 999) == 0) begin
        arst_n = 1'b0;
        #1;
        model_reset();
        check("rand_arst_speed", int'(speed), 0);
        @(posedge clk); #1;
        arst_n = 1'b1;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
